// File: rtl/fifo_word_unpacker.sv
// fifo_word_unpacker: pops FIFO show-ahead words and emits them LSB-first as narrow beats.
// Optional packet framing on m_last is built when FIFO_UNPACK_LAST_EN is defined.
module fifo_word_unpacker #(
    parameter int IN_WIDTH  = 32,
    parameter int OUT_WIDTH = 8,
    parameter int PKT_WORDS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [IN_WIDTH-1:0]  fifo_data,
    input  logic                 fifo_empty,
    output logic                 fifo_rd_en,
    output logic [OUT_WIDTH-1:0] m_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 m_last,
    output logic                 busy
);

    localparam int RATIO = IN_WIDTH / OUT_WIDTH;
    localparam int CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(RATIO - 1);

    if ((IN_WIDTH % OUT_WIDTH) != 0 || RATIO < 2 || PKT_WORDS < 1) begin : g_bad_cfg
        $error("fifo_word_unpacker: invalid IN_WIDTH/OUT_WIDTH/PKT_WORDS");
    end

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic [IN_WIDTH-1:0]  word_q;
    logic [CNT_W-1:0]     slice_cnt;
    logic                 accept;
    logic                 last_slice;

    assign accept     = m_valid & m_ready;
    assign last_slice = (slice_cnt == LAST_IDX);
    assign fifo_rd_en = !fifo_empty &
                        ((state_q == IDLE) | (accept & last_slice));

    assign m_valid = (state_q == ACTIVE);
    assign busy    = m_valid;
    assign m_data  = word_q[slice_cnt*OUT_WIDTH +: OUT_WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (fifo_rd_en) begin
                    state_d = ACTIVE;
                end
            end
            ACTIVE: begin
                if (accept && last_slice && !fifo_rd_en) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A refill on the last-slice accept keeps beats back to back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q    <= '0;
            slice_cnt <= '0;
        end else if (fifo_rd_en) begin
            word_q    <= fifo_data;
            slice_cnt <= '0;
        end else if (accept) begin
            if (last_slice) begin
                slice_cnt <= '0;
            end else begin
                slice_cnt <= slice_cnt + 1'b1;
            end
        end
    end

`ifdef FIFO_UNPACK_LAST_EN
    localparam int PKT_W = $clog2(PKT_WORDS) + 1;
    localparam logic [PKT_W-1:0] PKT_MAX = PKT_W'(PKT_WORDS - 1);

    logic [PKT_W-1:0] word_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_cnt <= '0;
        end else if (accept && last_slice) begin
            if (word_cnt == PKT_MAX) begin
                word_cnt <= '0;
            end else begin
                word_cnt <= word_cnt + 1'b1;
            end
        end
    end

    assign m_last = m_valid & last_slice & (word_cnt == PKT_MAX);
`else
    assign m_last = 1'b0;
`endif

endmodule

// File: doc/fifo_word_unpacker.md
# fifo_word_unpacker

Downstream read-side stage for the register-based synchronous FIFO. It pops IN_WIDTH-wide words from the FIFO's show-ahead port and serialises each word into RATIO = IN_WIDTH/OUT_WIDTH narrower beats on a valid/ready stream, LSB slice first. It sustains one beat per cycle with no bubbles between words, and optionally marks packet boundaries.

## Interface
- IN_WIDTH, 32, FIFO word width; must equal the FIFO DATA_WIDTH.
- OUT_WIDTH, 8, output beat width. IN_WIDTH % OUT_WIDTH must be 0 and RATIO must be ≥ 2; otherwise elaboration fails with $error.
- PKT_WORDS, 4, FIFO words per packet (≥ 1); used only when FIFO_UNPACK_LAST_EN is defined.
- Reset rst_n, asynchronous, active-low; clock clk.
- clk  input  1  clock
- rst_n  input  1  async active-low reset
- fifo_data  input  IN_WIDTH  FIFO show-ahead head word, valid whenever fifo_empty=0
- fifo_empty  input  1  FIFO empty flag
- fifo_rd_en  output  1  pop strobe to FIFO
- m_data  output  OUT_WIDTH  current beat
- m_valid  output  1  beat valid
- m_ready  input  1  sink accepts beat
- m_last  output  1  final beat of packet (see Configuration)
- busy  output  1  holding register occupied (equals m_valid)

## Operation
- State: word_q (IN_WIDTH), slice_cnt ($clog2(RATIO) bits), and a two-state FSM, IDLE (no word held) / ACTIVE (word held).
- accept = m_valid & m_ready. last_slice = (slice_cnt == RATIO-1).
- fifo_rd_en is combinational: !fifo_empty & (IDLE | (accept & last_slice)). It is never asserted while fifo_empty=1.
- On fifo_rd_en: word_q <= fifo_data, slice_cnt <= 0, and the FSM goes to or stays in ACTIVE.
- On accept without last_slice: slice_cnt <= slice_cnt+1.
- On accept with last_slice and no fifo_rd_en: ACTIVE -> IDLE and slice_cnt <= 0.
- m_valid = (state == ACTIVE). m_data = word_q[slice_cnt*OUT_WIDTH +: OUT_WIDTH].
- m_data and m_valid are stable while m_valid=1 and m_ready=0. m_valid never drops without an accept.
- The beat order within a word is slice 0 (bits OUT_WIDTH-1:0) first and slice RATIO-1 last.

## Timing
- Reset values: state IDLE, word_q 0, slice_cnt 0, m_valid 0, m_data 0, m_last 0, busy 0. fifo_rd_en is 0 whenever fifo_empty=1.
- Latency: with the FIFO going non-empty at edge N while IDLE, fifo_rd_en is high in cycle N and the first beat is valid in cycle N+1.
- Throughput: with m_ready held at 1 and the FIFO non-empty, output is 1 beat per cycle. The last beat of word k and the first beat of word k+1 are on consecutive cycles, and the FIFO pops once every RATIO cycles.
- FIFO empty at a last-slice accept: the FSM returns to IDLE and m_valid goes to 0 in the next cycle.
- m_ready=0 on the last slice: no pop occurs, even if the FIFO is full.
- Reset mid-word: the held word and the remaining slices are discarded. Words already popped are not recovered. Reset also clears the packet counter.

## Configuration
- Macro FIFO_UNPACK_LAST_EN.
- Defined:
  - A word counter of $clog2(PKT_WORDS)+1 bits, reset 0, increments on each last-slice accept and wraps to 0 after PKT_WORDS-1.
  - m_last = m_valid & last_slice & (word counter == PKT_WORDS-1).
  - PKT_WORDS=1 sets m_last on every word's final beat.
- Undefined: the counter is not built and m_last is tied to 0.

## Test plan
- Single word: IN=32, OUT=8. Push 0xDDCCBBAA with m_ready=1 -> beats 0xAA, 0xBB, 0xCC, 0xDD on 4 consecutive cycles. The first beat appears 1 cycle after fifo_empty falls, fifo_rd_en pulses once, then m_valid=0.
- Streaming: preload 3 words with m_ready=1 -> 12 contiguous beats with no m_valid gaps. fifo_rd_en is high in cycles 0, 4 and 8 only.
- Backpressure: hold m_ready=0 for 5 cycles on slice 2 of 0x44332211 -> m_data stays 0x33 and m_valid stays 1 throughout, with no pop. After release the beats are 0x33 then 0x44.
- Empty edge: push 1 word and let it drain -> m_valid deasserts after 0x..DD, and fifo_rd_en never asserts while fifo_empty=1.
- Mid-word reset: assert rst_n=0 after beat 1 -> m_valid, m_data and m_last are 0 immediately. After release, the next FIFO word starts at slice 0.
- With FIFO_UNPACK_LAST_EN and PKT_WORDS=4: stream 8 words -> m_last is high only on beats 16 and 32, and all other beats have m_last=0.
